// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a first-word-fall-through receive FIFO with sticky error flags
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ser_rx,
  input  logic [15:0]                  cfg_div,
  input  logic                         rd_en,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic                         rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  input  logic                         err_clr,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state;
  logic                 sync1, sync2, rx_prev;
  logic                 rx_s, fall;
  logic [15:0]          eff_div, half_div, cnt;
  logic                 expire;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, frm_bad, frm_bad_now, par_exp;
  logic                 end_frame, wr_en;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, do_rd, do_wr;

  assign rx_s     = sync2;
  assign fall     = rx_prev & ~sync2;
  assign eff_div  = (cfg_div < 16'd4) ? 16'd4 : cfg_div;
  assign half_div = eff_div >> 1;
  assign expire   = (cnt <= 16'd1);
  assign par_exp  = (PARITY == 1) ? ~(^shreg) : (^shreg);

  // Two-flop synchronizer plus one extra stage for falling-edge detection; idle level is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= ser_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // Receive FSM: bit timer reloads read cfg_div fresh, so a divider change only affects the next bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            cnt   <= half_div;
          end
        end
        ST_START: begin
          if (expire) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              cnt     <= eff_div;
              bit_idx <= '0;
              par_bad <= 1'b0;
              frm_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (expire) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= eff_div;
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_PARITY: begin
          if (expire) begin
            par_bad <= (rx_s != par_exp);
            cnt     <= eff_div;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (expire) begin
            if (!rx_s) frm_bad <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              state <= ST_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
              cnt      <= eff_div;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The last stop sample is folded in combinationally so a good frame is written on that same cycle
  assign end_frame   = (state == ST_STOP) && expire && (stop_idx == LAST_STOP);
  assign frm_bad_now = frm_bad | ~rx_s;
  assign wr_en       = end_frame & ~frm_bad_now & ~par_bad;

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign do_rd    = rd_en && (fifo_count != '0);
  assign do_wr    = wr_en && (!full || do_rd);
  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy; a read and write together leave the count unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (end_frame && frm_bad_now) frame_err <= 1'b1;
      else if (err_clr)             frame_err <= 1'b0;
      if (end_frame && par_bad)     parity_err <= 1'b1;
      else if (err_clr)             parity_err <= 1'b0;
      if (wr_en && full && !do_rd)  overrun <= 1'b1;
      else if (err_clr)             overrun <= 1'b0;
    end
  end

endmodule
